alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Multicycle control FSM for the CPU datapath. Sequences fetch/decode/execute and drives the
//  ALU operand muxes: the B-operand select encodes B / const 4 / sign-ext / sign-ext<<2 / mem.
//  It also drives the ALU op and all PC, IR, memory and register-file write strobes.
//  Supports R-type add/sub/and, addi, lw, sw, beq and j. Illegal opcodes trap to a halt state.
// PARAMETERS
//  MEM_WAIT  2  cycles a memory access is held (mem_read/mem_write asserted), >=1
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  reset        in   1  synchronous, active-high
//  opcode       in   6  IR[31:26]
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU zero flag
//  alusrcA_sel  out  2  00 PC, 01 A
//  alusrcB_sel  out  3  000 B, 001 4, 010 sign-ext, 011 sign-ext<<2 (100 mem: never issued)
//  alu_op       out  3  000 pass A, 001 add, 010 sub, 011 and
//  pc_write     out  1  PC load strobe
//  pc_src       out  2  00 ALU result, 01 ALUOut, 10 jump target
//  iord         out  1  0 addr=PC, 1 addr=ALUOut
//  mem_read     out  1  memory read
//  mem_write    out  1  memory write
//  ir_write     out  1  IR load strobe
//  aluout_write out  1  ALUOut load strobe
//  reg_write    out  1  register-file write strobe
//  reg_dst      out  1  0 rt, 1 rd
//  mem_to_reg   out  1  0 ALUOut, 1 MDR
//  halted       out  1  high in ILLEGAL state
//  state_out    out  4  current state encoding (debug)
// BEHAVIOUR
//  - Moore outputs decoded from state + wait counter. Unlisted outputs are 0; alusrcB_sel defaults to 000.
//  - While reset=1, all strobes are forced 0 combinationally.
//  - At the next edge with reset=1: state<=RST, wcnt<=0. RST outputs are all 0.
//  - Reset mid-access aborts the access; no partial writes occur.
//  - States: RST(0) FETCH(1) DECODE(2) EXEC_R(3) R_WB(4) ADDR(5) MEM_RD(6) LW_WB(7)
//    MEM_WR(8) BRANCH(9) JUMP(10) ADDI_EX(11) ADDI_WB(12) ILLEGAL(13).
//  - RST -> FETCH after 1 cycle.
//  - FETCH: mem_read=1, iord=0, srcA=00, srcB=001, alu_op=001.
//    Held MEM_WAIT cycles using wcnt.
//    On the last cycle (wcnt==MEM_WAIT-1), ir_write=1 and pc_write=1 (pc_src=00), then -> DECODE, wcnt<=0.
//  - DECODE: srcA=00, srcB=011, alu_op=001, aluout_write=1 (branch target precompute). Next state by opcode:
//    0x00->EXEC_R; 0x23,0x2B->ADDR; 0x04->BRANCH; 0x02->JUMP; 0x08->ADDI_EX; else ILLEGAL.
//  - EXEC_R: srcA=01, srcB=000, aluout_write=1, alu_op by funct: 0x20 add, 0x22 sub, 0x24 and.
//    Any other funct -> ILLEGAL (no aluout_write). Otherwise -> R_WB.
//  - R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
//  - ADDR: srcA=01, srcB=010, alu_op=001, aluout_write=1. -> MEM_RD for 0x23, MEM_WR for 0x2B.
//  - MEM_RD / MEM_WR: iord=1, mem_read / mem_write held MEM_WAIT cycles.
//    MEM_RD then -> LW_WB; MEM_WR then -> FETCH.
//  - LW_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
//  - BRANCH: srcA=01, srcB=000, alu_op=010. pc_write=zero, pc_src=01 -> FETCH.
//  - JUMP: pc_write=1, pc_src=10 -> FETCH.
//  - ADDI_EX: srcA=01, srcB=010, alu_op=001, aluout_write=1 -> ADDI_WB.
//  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
//  - ILLEGAL: halted=1, all strobes 0, absorbing until reset.
//  - Cycle counts with MEM_WAIT=2: R 5, addi 5, lw 7, sw 6, beq 4, j 4.
//  - wcnt is clog2(MEM_WAIT+1) bits wide, cleared on every state change, never wraps.
// TESTING
//  - Reset held 3 cycles, then released: strobes 0 during reset; state_out 0 -> 1; mem_read=1 on the first FETCH cycle.
//  - opcode=0x00, funct=0x22: states 1,1,2,3,4,1. EXEC_R drives srcB=000, alu_op=010; R_WB drives reg_write=1, reg_dst=1.
//  - opcode=0x23 (lw): ADDR drives srcB=010; MEM_RD holds iord=1, mem_read=1 for exactly 2 cycles;
//    LW_WB drives mem_to_reg=1. 7 cycles total.
//  - opcode=0x04 with zero=1, then zero=0: DECODE drives srcB=011 and aluout_write=1.
//    BRANCH pc_write=1 (pc_src=01) in the first case, 0 in the second.
//  - opcode=0x3F: DECODE -> ILLEGAL, halted=1 and all strobes 0 for 10 cycles. Reset -> RST, halted=0.
//  - Reset asserted on the 1st MEM_WR cycle of sw: mem_write drops to 0 in that same cycle; state_out=0 after the edge.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Multicycle control FSM for the CPU datapath: sequences fetch/decode/execute and
// drives the ALU operand muxes, ALU op and all PC/IR/memory/register-file strobes.
module alu_seq_ctrl #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [1:0] alusrcA_sel,
  output logic [2:0] alusrcB_sel,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       aluout_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       halted,
  output logic [3:0] state_out
);

  localparam int WCNT_W = (MEM_WAIT < 2) ? 1 : $clog2(MEM_WAIT + 1);

  localparam logic [3:0] S_RST     = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EXEC_R  = 4'd3;
  localparam logic [3:0] S_R_WB    = 4'd4;
  localparam logic [3:0] S_ADDR    = 4'd5;
  localparam logic [3:0] S_MEM_RD  = 4'd6;
  localparam logic [3:0] S_LW_WB   = 4'd7;
  localparam logic [3:0] S_MEM_WR  = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_JUMP    = 4'd10;
  localparam logic [3:0] S_ADDI_EX = 4'd11;
  localparam logic [3:0] S_ADDI_WB = 4'd12;
  localparam logic [3:0] S_ILLEGAL = 4'd13;

  logic [3:0]        state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              wait_done;

  assign wait_done = (wcnt_q == WCNT_W'(MEM_WAIT - 1));
  assign state_out = state_q;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (wait_done) state_d = S_DECODE; else wcnt_d = wcnt_q + 1'b1;
      S_DECODE: begin
        case (opcode)
          6'h00:        state_d = S_EXEC_R;
          6'h23, 6'h2B: state_d = S_ADDR;
          6'h04:        state_d = S_BRANCH;
          6'h02:        state_d = S_JUMP;
          6'h08:        state_d = S_ADDI_EX;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        if (funct == 6'h20 || funct == 6'h22 || funct == 6'h24) state_d = S_R_WB;
        else                                                    state_d = S_ILLEGAL;
      end
      S_ADDR:    state_d = (opcode == 6'h2B) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (wait_done) state_d = S_LW_WB; else wcnt_d = wcnt_q + 1'b1;
      S_MEM_WR:  if (wait_done) state_d = S_FETCH; else wcnt_d = wcnt_q + 1'b1;
      S_R_WB, S_LW_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_ILLEGAL;
    endcase
    if (state_d != state_q) wcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    alusrcA_sel  = 2'b00;
    alusrcB_sel  = 3'b000;
    alu_op       = 3'b000;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    aluout_write = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read    = 1'b1;
        alusrcB_sel = 3'b001;
        alu_op      = 3'b001;
        ir_write    = wait_done;
        pc_write    = wait_done;
      end
      // Branch target is precomputed here so BRANCH only needs the compare.
      S_DECODE: begin
        alusrcB_sel  = 3'b011;
        alu_op       = 3'b001;
        aluout_write = 1'b1;
      end
      S_EXEC_R: begin
        alusrcA_sel = 2'b01;
        case (funct)
          6'h20:   begin alu_op = 3'b001; aluout_write = 1'b1; end
          6'h22:   begin alu_op = 3'b010; aluout_write = 1'b1; end
          6'h24:   begin alu_op = 3'b011; aluout_write = 1'b1; end
          default: alu_op = 3'b000;
        endcase
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDR, S_ADDI_EX: begin
        alusrcA_sel  = 2'b01;
        alusrcB_sel  = 3'b010;
        alu_op       = 3'b001;
        aluout_write = 1'b1;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_LW_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alusrcA_sel = 2'b01;
        alu_op      = 3'b010;
        pc_write    = zero;
        pc_src      = 2'b01;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      S_ADDI_WB: reg_write = 1'b1;
      S_ILLEGAL: halted = 1'b1;
      default: halted = 1'b0;
    endcase
    // Strobes are suppressed as soon as reset rises so an aborted access never writes.
    if (reset) begin
      pc_write     = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      aluout_write = 1'b0;
      reg_write    = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed testbench for alu_seq_ctrl: walks each instruction class through the FSM
// and compares state and control outputs against hand-computed values.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [1:0] alusrcA_sel;
  logic [2:0] alusrcB_sel;
  logic [2:0] alu_op;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       aluout_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       halted;
  logic [3:0] state_out;

  int checks = 0;
  int errors = 0;

  alu_seq_ctrl #(.MEM_WAIT(2)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .alusrcA_sel(alusrcA_sel), .alusrcB_sel(alusrcB_sel), .alu_op(alu_op),
    .pc_write(pc_write), .pc_src(pc_src), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .aluout_write(aluout_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .halted(halted), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [5:0] strobes;
    reset = 1'b1;
    #1;
    strobes = {pc_write, mem_read, mem_write, ir_write, aluout_write, reg_write};
    checks++;
    if (strobes !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_strobes_t0: got %b expected 000000", strobes);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      strobes = {pc_write, mem_read, mem_write, ir_write, aluout_write, reg_write};
      checks++;
      if (strobes !== 6'b0 || state_out !== 4'd0) begin
        errors++;
        $display("[TB] FAIL reset_hold[%0d]: strobes %b state %0d expected 000000 state 0", i, strobes, state_out);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (state_out !== 4'd0 || mem_read !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_state: state %0d mem_read %b expected 0 0", state_out, mem_read);
    end
    tick();
    checks++;
    if (state_out !== 4'd1 || mem_read !== 1'b1 || iord !== 1'b0 || alusrcB_sel !== 3'b001
        || alu_op !== 3'b001 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_fetch: state %0d mem_read %b iord %b srcB %b alu_op %b ir_write %b pc_write %b expected 1 1 0 001 001 0 0",
               state_out, mem_read, iord, alusrcB_sel, alu_op, ir_write, pc_write);
    end
  endtask

  task automatic test_rtype_sub();
    logic [3:0] exp [6] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    opcode = 6'h00; funct = 6'h22;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (state_out !== exp[i]) begin
        errors++; $display("[TB] FAIL rsub_state[%0d]: got %0d expected %0d", i, state_out, exp[i]);
      end
      if (i == 1) begin
        checks++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1 || pc_src !== 2'b00) begin
          errors++; $display("[TB] FAIL fetch_last: ir_write %b pc_write %b pc_src %b expected 1 1 00", ir_write, pc_write, pc_src);
        end
      end
      if (i == 3) begin
        checks++;
        if (alusrcA_sel !== 2'b01 || alusrcB_sel !== 3'b000 || alu_op !== 3'b010 || aluout_write !== 1'b1) begin
          errors++; $display("[TB] FAIL exec_r_sub: srcA %b srcB %b alu_op %b aluout_write %b expected 01 000 010 1",
                             alusrcA_sel, alusrcB_sel, alu_op, aluout_write);
        end
      end
      if (i == 4) begin
        checks++;
        if (reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
          errors++; $display("[TB] FAIL r_wb: reg_write %b reg_dst %b mem_to_reg %b expected 1 1 0", reg_write, reg_dst, mem_to_reg);
        end
      end
    end
  endtask

  task automatic test_rtype_and();
    opcode = 6'h00; funct = 6'h24;
    tick(); tick(); tick();
    checks++;
    if (state_out !== 4'd3 || alu_op !== 3'b011 || aluout_write !== 1'b1) begin
      errors++; $display("[TB] FAIL exec_r_and: state %0d alu_op %b aluout_write %b expected 3 011 1", state_out, alu_op, aluout_write);
    end
    tick(); tick();
  endtask

  task automatic test_lw();
    logic [3:0] exp [8] = '{4'd1, 4'd1, 4'd2, 4'd5, 4'd6, 4'd6, 4'd7, 4'd1};
    int reads = 0;
    opcode = 6'h23;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      checks++;
      if (state_out !== exp[i]) begin
        errors++; $display("[TB] FAIL lw_state[%0d]: got %0d expected %0d", i, state_out, exp[i]);
      end
      if (i >= 3 && i <= 6 && mem_read === 1'b1 && iord === 1'b1) reads++;
      if (i == 3) begin
        checks++;
        if (alusrcA_sel !== 2'b01 || alusrcB_sel !== 3'b010 || alu_op !== 3'b001 || aluout_write !== 1'b1) begin
          errors++; $display("[TB] FAIL addr: srcA %b srcB %b alu_op %b aluout_write %b expected 01 010 001 1",
                             alusrcA_sel, alusrcB_sel, alu_op, aluout_write);
        end
      end
      if (i == 6) begin
        checks++;
        if (reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b1) begin
          errors++; $display("[TB] FAIL lw_wb: reg_write %b reg_dst %b mem_to_reg %b expected 1 0 1", reg_write, reg_dst, mem_to_reg);
        end
      end
    end
    checks++;
    if (reads != 2) begin
      errors++; $display("[TB] FAIL mem_rd_cycles: got %0d expected 2", reads);
    end
  endtask

  task automatic test_branch(input logic z);
    opcode = 6'h04; zero = z;
    tick(); tick();
    checks++;
    if (state_out !== 4'd2 || alusrcA_sel !== 2'b00 || alusrcB_sel !== 3'b011 || aluout_write !== 1'b1) begin
      errors++; $display("[TB] FAIL decode_beq: state %0d srcA %b srcB %b aluout_write %b expected 2 00 011 1",
                         state_out, alusrcA_sel, alusrcB_sel, aluout_write);
    end
    tick();
    checks++;
    if (state_out !== 4'd9 || pc_write !== z || pc_src !== 2'b01 || alu_op !== 3'b010 || alusrcA_sel !== 2'b01) begin
      errors++; $display("[TB] FAIL branch_z%0d: state %0d pc_write %b pc_src %b alu_op %b srcA %b expected 9 %b 01 010 01",
                         z, state_out, pc_write, pc_src, alu_op, alusrcA_sel, z);
    end
    tick();
    checks++;
    if (state_out !== 4'd1) begin
      errors++; $display("[TB] FAIL branch_ret: state %0d expected 1", state_out);
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    opcode = 6'h02;
    tick(); tick(); tick();
    checks++;
    if (state_out !== 4'd10 || pc_write !== 1'b1 || pc_src !== 2'b10) begin
      errors++; $display("[TB] FAIL jump: state %0d pc_write %b pc_src %b expected 10 1 10", state_out, pc_write, pc_src);
    end
    tick();
    checks++;
    if (state_out !== 4'd1) begin
      errors++; $display("[TB] FAIL jump_ret: state %0d expected 1", state_out);
    end
  endtask

  task automatic test_addi();
    opcode = 6'h08;
    tick(); tick(); tick();
    checks++;
    if (state_out !== 4'd11 || alusrcB_sel !== 3'b010 || alu_op !== 3'b001 || aluout_write !== 1'b1) begin
      errors++; $display("[TB] FAIL addi_ex: state %0d srcB %b alu_op %b aluout_write %b expected 11 010 001 1",
                         state_out, alusrcB_sel, alu_op, aluout_write);
    end
    tick();
    checks++;
    if (state_out !== 4'd12 || reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0) begin
      errors++; $display("[TB] FAIL addi_wb: state %0d reg_write %b reg_dst %b mem_to_reg %b expected 12 1 0 0",
                         state_out, reg_write, reg_dst, mem_to_reg);
    end
    tick();
    checks++;
    if (state_out !== 4'd1) begin
      errors++; $display("[TB] FAIL addi_ret: state %0d expected 1", state_out);
    end
  endtask

  task automatic test_illegal();
    logic [5:0] strobes;
    opcode = 6'h3F;
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++) begin
      strobes = {pc_write, mem_read, mem_write, ir_write, aluout_write, reg_write};
      checks++;
      if (state_out !== 4'd13 || halted !== 1'b1 || strobes !== 6'b0) begin
        errors++; $display("[TB] FAIL illegal[%0d]: state %0d halted %b strobes %b expected 13 1 000000", i, state_out, halted, strobes);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    checks++;
    if (state_out !== 4'd0 || halted !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_reset: state %0d halted %b expected 0 0", state_out, halted);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_bad_funct();
    opcode = 6'h00; funct = 6'h3F;
    tick(); tick(); tick();
    checks++;
    if (state_out !== 4'd3 || aluout_write !== 1'b0) begin
      errors++; $display("[TB] FAIL bad_funct_exec: state %0d aluout_write %b expected 3 0", state_out, aluout_write);
    end
    tick();
    checks++;
    if (state_out !== 4'd13 || halted !== 1'b1) begin
      errors++; $display("[TB] FAIL bad_funct_trap: state %0d halted %b expected 13 1", state_out, halted);
    end
    funct = 6'h20;
    restart();
  endtask

  task automatic test_sw_reset();
    opcode = 6'h2B;
    tick(); tick(); tick(); tick();
    checks++;
    if (state_out !== 4'd8 || mem_write !== 1'b1 || iord !== 1'b1) begin
      errors++; $display("[TB] FAIL sw_mem_wr: state %0d mem_write %b iord %b expected 8 1 1", state_out, mem_write, iord);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0) begin
      errors++; $display("[TB] FAIL sw_abort_comb: mem_write %b expected 0", mem_write);
    end
    tick();
    checks++;
    if (state_out !== 4'd0 || mem_write !== 1'b0) begin
      errors++; $display("[TB] FAIL sw_abort_state: state %0d mem_write %b expected 0 0", state_out, mem_write);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_sw_full();
    opcode = 6'h2B;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (state_out !== 4'd1) begin
      errors++; $display("[TB] FAIL sw_cycles: state %0d expected 1 after 6 cycles", state_out);
    end
  endtask

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
    test_reset();
    test_rtype_sub();
    test_rtype_and();
    test_lw();
    test_branch(1'b1);
    test_branch(1'b0);
    test_jump();
    test_addi();
    test_sw_full();
    test_bad_funct();
    test_illegal();
    test_sw_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
